// File: rtl/rv32m_muldiv.sv
// rv32m_muldiv: iterative RV32M multiply/divide unit, one bit per cycle.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   flush            abort in-flight work and drop any pending response
//   req_*            request port: valid/ready, funct3, rs1 (a), rs2 (b), tag
//   resp_*           response port: valid/ready, data, tag
//   busy             high while in BUSY or DONE
//   dbg_state        raw FSM state (IDLE=0, BUSY=1, DONE=2) for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload stable until that edge,
// and ready never depends combinationally on valid.
//
// Datapath: hi_q/lo_q form a 2*WIDTH shift register shared by both classes.
//   multiply: lo_q starts as |a| (multiplier), dsor_q holds |b|; each cycle
//             adds dsor_q into hi_q when lo_q[0] is set, then shifts right.
//   divide:   lo_q starts as |a| (dividend), dsor_q holds |b|; each cycle
//             shifts the dividend MSB into the partial remainder and shifts
//             the quotient bit into lo_q[0] (restoring division).
// Signs are applied once, on the final iteration.
module rv32m_muldiv #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, dsor_q, dsor_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

  // Request decode
  logic             accept, a_signed, b_signed, a_neg_in, b_neg_in;
  logic             b_zero, ovf, special_in;
  logic [WIDTH-1:0] mag_a, mag_b, special_res;

  // Iteration and result
  logic [WIDTH:0]     sum, shifted, diff;
  logic               ge;
  logic [WIDTH-1:0]   mul_hi, mul_lo, div_hi, div_lo;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, final_res;

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_tag   = resp_tag_q;

  always_comb begin
    accept   = req_valid && (state_q == IDLE) && !flush;
    a_signed = (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
               (req_funct3 == 3'b100) || (req_funct3 == 3'b110);
    b_signed = (req_funct3 == 3'b001) || (req_funct3 == 3'b100) ||
               (req_funct3 == 3'b110);
    a_neg_in = a_signed && req_a[WIDTH-1];
    b_neg_in = b_signed && req_b[WIDTH-1];
    mag_a    = a_neg_in ? -req_a : req_a;
    mag_b    = b_neg_in ? -req_b : req_b;
    b_zero   = (req_b == '0);
    ovf      = !req_funct3[0] && (req_a == MIN_VAL) && (req_b == '1);
    special_in = req_funct3[2] && (b_zero || ovf);
    // funct3[1] distinguishes rem/remu from div/divu
    if (b_zero) special_res = req_funct3[1] ? req_a : '1;
    else        special_res = req_funct3[1] ? '0 : req_a;
  end

  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dsor_q} : '0);
    mul_hi  = sum[WIDTH:1];
    mul_lo  = {sum[0], lo_q[WIDTH-1:1]};
    // The partial remainder is always below the divisor, so the shifted value
    // is below twice the divisor and the difference sign bit decides the bit.
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dsor_q};
    ge      = !diff[WIDTH];
    div_hi  = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    div_lo  = {lo_q[WIDTH-2:0], ge};
    prod    = {mul_hi, mul_lo};
    prod_s  = (sa_q ^ sb_q) ? -prod : prod;
    quo_s   = (sa_q ^ sb_q) ? -div_lo : div_lo;
    rem_s   = sa_q ? -div_hi : div_hi;
    case (f3_q)
      3'b000:                 final_res = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         final_res = quo_s;
      default:                final_res = rem_s;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    f3_d         = f3_q;
    tag_d        = tag_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    dsor_d       = dsor_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_tag_d   = resp_tag_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          f3_d   = req_funct3;
          tag_d  = req_tag;
          sa_d   = a_neg_in;
          sb_d   = b_neg_in;
          hi_d   = '0;
          lo_d   = mag_a;
          dsor_d = mag_b;
          if (special_in) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_data_d  = special_res;
            resp_tag_d   = req_tag;
          end else begin
            state_d = BUSY;
            cnt_d   = CW'(WIDTH - 1);
          end
        end
      end
      BUSY: begin
        hi_d = f3_q[2] ? div_hi : mul_hi;
        lo_d = f3_q[2] ? div_lo : mul_lo;
        if (cnt_q == '0) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_data_d  = final_res;
          resp_tag_d   = tag_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // flush wins over accept and over a same-cycle response handshake
    if (flush) begin
      state_d      = IDLE;
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      f3_q         <= '0;
      tag_q        <= '0;
      sa_q         <= 1'b0;
      sb_q         <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      dsor_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      f3_q         <= f3_d;
      tag_q        <= tag_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      dsor_q       <= dsor_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
    end
  end

endmodule

// File: doc/rv32m_muldiv.md
# rv32m_muldiv

Iterative multiply/divide unit implementing the eight RV32M operations (`mul`, `mulh`, `mulhsu`, `mulhu`, `div`, `divu`, `rem`, `remu`), parametrised in operand width. It sits beside the ALU in EX. EX issues an `op_reg` instruction with funct7 = 7'b0000001 through a valid/ready request port. The pipeline stalls until the tagged result returns on a valid/ready response port toward MEM/WB. A flush input aborts in-flight work on branch mispredict.

## Interface
- `WIDTH`, 32: operand and result width in bits, even, ≥ 4.
- `TAG_W`, 5: width of the opaque tag (destination register) carried from request to response.
- `clk` in 1: the unit's only clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: abort current operation and discard any pending response.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_funct3` in 3: RV32M funct3 encoding: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- `req_a` in WIDTH: rs1 operand.
- `req_b` in WIDTH: rs2 operand.
- `req_tag` in TAG_W: passed through unchanged.
- `resp_valid` out 1: result present.
- `resp_ready` in 1: consumer takes result.
- `resp_data` out WIDTH: result.
- `resp_tag` out TAG_W: tag of the result.
- `busy` out 1: high in BUSY or DONE state.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_data`=0, `resp_tag`=0, `busy`=0, iteration counter=0.
- **Accept.** A request is accepted when `req_valid && req_ready && !flush`. `req_ready` is high only in IDLE.
  - On accept, latch funct3, tag, operand signs and operand magnitudes.
  - Signedness: rs1 is signed for mulh, mulhsu, div and rem. rs2 is signed for mulh, div and rem. All other operands are unsigned.
- **Special cases** (divide class only) go IDLE→DONE directly on accept:
  - b == 0: div/divu return all-ones; rem/remu return `req_a` unchanged.
  - Signed overflow (a == 1<<(WIDTH-1), b == all-ones, div/rem): div returns a; rem returns 0.
- **Normal case** goes IDLE→BUSY. The counter loads WIDTH−1.
  - Multiply: radix-2 shift-add over magnitudes into a 2·WIDTH-bit accumulator, one multiplier bit per cycle.
  - Divide: restoring division, one quotient bit per cycle. Partial remainder is WIDTH+1 bits.
- **BUSY→DONE** on the cycle the counter is 0 (after WIDTH iterations). Then apply sign correction:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- **Result select:**
  - mul: product[WIDTH-1:0].
  - mulh, mulhsu, mulhu: product[2·WIDTH-1:WIDTH].
  - div/divu: quotient.
  - rem/remu: remainder.
  - mul with a zero operand takes no early exit; it uses the full WIDTH iterations.
- **DONE:** `resp_valid`=1. `resp_data` and `resp_tag` are held stable until `resp_ready`. On handshake go to IDLE.
- **flush:** from any state, the next state is IDLE and `resp_valid` drops next cycle.
  - flush takes priority over a same-cycle accept (request not taken) and over a same-cycle response handshake (response considered dropped).
- `rst` mid-operation: all registers return to reset values next cycle; no response is produced.

## Timing
- Accept at edge 0 (normal case): BUSY occupies cycles 1..WIDTH; `resp_valid` rises at cycle WIDTH+1. Latency is WIDTH+1 cycles (33 at WIDTH=32).
- Special case: `resp_valid` at cycle 1.
- Minimum issue interval: normal WIDTH+2 cycles, special 2 cycles. The IDLE cycle after the response handshake is mandatory: no back-to-back accept on the handshake cycle.
- `resp_valid` held with `resp_ready` low: output is stable indefinitely.
- All outputs are registered, except `req_ready` and `busy`, which are decoded from the state register only (no input-to-output combinational path).

## Test plan
- **mulh / mulhu, WIDTH=32:** a=0xFFFFFFFF, b=0xFFFFFFFF. mulh → 0x00000000; mulhu → 0xFFFFFFFE; mul → 0x00000001. `resp_valid` exactly 33 cycles after accept.
- **div / rem signed:** a=-7 (0xFFFFFFF9), b=2. div → 0xFFFFFFFD (-3); rem → 0xFFFFFFFF (-1). divu with the same operands → 0x7FFFFFFC.
- **Special cases:**
  - div 5/0 → 0xFFFFFFFF; rem 5%0 → 5.
  - div 0x80000000 / 0xFFFFFFFF → 0x80000000; rem → 0.
  - Each responds 1 cycle after accept, with tag echoed.
- **Backpressure:** hold `resp_ready`=0 for 10 cycles after `resp_valid`. Data and tag are stable and `req_ready`=0 throughout. After the handshake, the next request is accepted only one cycle later.
- **Flush and reset:**
  - Assert flush at BUSY cycle 10: IDLE next cycle, no response.
  - Assert flush with `req_valid` high in IDLE: not accepted.
  - Assert `rst` in DONE: `resp_valid`=0 next cycle.
- **Parametric:** WIDTH=8, mulhsu a=0x80 (-128), b=0xFF (255) → 0x80; latency 9 cycles. Random signed/unsigned sweep against a reference model for WIDTH=8 and WIDTH=32.
